// File: rtl/irq_watchdog_ctrl.sv
// Periodic IRQ generator with a missed-acknowledge watchdog that pulses a CPU reset.
// Timebase ticks every IRQ_PERIOD Ce strobes; WDOG_LIMIT unkicked ticks fire a RST_CYCLES-long reset.
module irq_watchdog_ctrl #(
    parameter int unsigned IRQ_PERIOD = 1024,
    parameter int unsigned WDOG_LIMIT = 8,
    parameter int unsigned RST_CYCLES = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Ce,
    input  logic       Irq_ack,
    input  logic       Wdog_kick,
    input  logic       Wdog_en,
    output logic       Irq_n,
    output logic       Cpu_reset,
    output logic [7:0] Wdog_count
);

    localparam logic [15:0] DIV_LAST  = 16'(IRQ_PERIOD - 1);
    localparam logic [7:0]  CNT_LAST  = 8'(WDOG_LIMIT - 1);
    localparam logic [7:0]  FIRE_LAST = 8'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIRE = 2'd2
    } wd_state_e;

    logic [15:0] div_q, div_d;
    logic        tick;
    logic        irq_q, irq_d;
    logic        fire_enter;
    wd_state_e   state_q;
    logic [7:0]  cnt_q;
    logic [7:0]  fire_cnt_q;
    logic        cpu_reset_q;

    always_comb begin
        tick  = Ce && (div_q == DIV_LAST);
        div_d = div_q;
        if (Ce) begin
            div_d = tick ? 16'd0 : div_q + 16'd1;
        end
    end

    // A kick or a dropped enable in the same cycle pre-empts the fire.
    assign fire_enter = (state_q == RUN) && Wdog_en && !Wdog_kick && tick && (cnt_q == CNT_LAST);

    // Clearing on the entry cycle keeps Irq_n high for the whole reset pulse.
    always_comb begin
        irq_d = irq_q;
        if ((state_q == FIRE) || fire_enter) begin
            irq_d = 1'b0;
        end else if (tick) begin
            irq_d = 1'b1;
        end else if (Irq_ack) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            div_q <= 16'd0;
            irq_q <= 1'b0;
        end else begin
            div_q <= div_d;
            irq_q <= irq_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            fire_cnt_q  <= 8'd0;
            cpu_reset_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= 8'd0;
                    if (Wdog_en) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (!Wdog_en) begin
                        state_q <= IDLE;
                        cnt_q   <= 8'd0;
                    end else if (Wdog_kick) begin
                        cnt_q <= 8'd0;
                    end else if (fire_enter) begin
                        state_q     <= FIRE;
                        cnt_q       <= 8'd0;
                        fire_cnt_q  <= 8'd0;
                        cpu_reset_q <= 1'b1;
                    end else if (tick) begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                FIRE: begin
                    // Enable is only sampled on the way out of the reset pulse.
                    if (fire_cnt_q == FIRE_LAST) begin
                        cpu_reset_q <= 1'b0;
                        cnt_q       <= 8'd0;
                        fire_cnt_q  <= 8'd0;
                        state_q     <= Wdog_en ? RUN : IDLE;
                    end else begin
                        fire_cnt_q <= fire_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= 8'd0;
                    fire_cnt_q  <= 8'd0;
                    cpu_reset_q <= 1'b0;
                end
            endcase
        end
    end

    assign Irq_n      = ~irq_q;
    assign Cpu_reset  = cpu_reset_q;
    assign Wdog_count = cnt_q;

endmodule

// File: tb/tb_irq_watchdog_ctrl.sv
// Scoreboard bench for irq_watchdog_ctrl: expected output-change events are queued by the
// stimulus with their cycle stamps; the monitor pops one per observed change.
module tb_irq_watchdog_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Ce = 1'b0;
    logic       Irq_ack = 1'b0;
    logic       Wdog_kick = 1'b0;
    logic       Wdog_en = 1'b0;
    logic       Irq_n;
    logic       Cpu_reset;
    logic [7:0] Wdog_count;

    irq_watchdog_ctrl #(
        .IRQ_PERIOD(4),
        .WDOG_LIMIT(3),
        .RST_CYCLES(5)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Ce         (Ce),
        .Irq_ack    (Irq_ack),
        .Wdog_kick  (Wdog_kick),
        .Wdog_en    (Wdog_en),
        .Irq_n      (Irq_n),
        .Cpu_reset  (Cpu_reset),
        .Wdog_count (Wdog_count)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int         cyc;
        logic       irq_n;
        logic       rst;
        logic [7:0] cnt;
    } ev_t;

    ev_t        exp_q[$];
    int         cyc = 0;
    int         base = 0;
    int         checks = 0;
    int         failures = 0;
    logic       mon_on = 1'b0;
    logic       fin_req = 1'b0;
    logic       fin_done = 1'b0;
    logic [9:0] prev_q = 'x;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic expect_ev(input int k, input logic irqn, input logic rst, input int cnt);
        ev_t e;
        e.cyc   = base + k;
        e.irq_n = irqn;
        e.rst   = rst;
        e.cnt   = 8'(cnt);
        exp_q.push_back(e);
    endtask

    // Position so that inputs driven next are sampled at edge k of the current phase.
    task automatic goto(input int k);
        while (cyc < base + k - 1) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // Monitor: every change of the output tuple consumes one expected event.
    always @(negedge Clk) begin
        if (mon_on && ({Irq_n, Cpu_reset, Wdog_count} !== prev_q)) begin
            prev_q <= {Irq_n, Cpu_reset, Wdog_count};
            checks <= checks + 1;
            if (exp_q.size() == 0) begin
                failures <= failures + 1;
                $display("FAIL unexpected_change cyc=%0d got irq_n=%b cpu_reset=%b count=%0d required no change",
                         cyc, Irq_n, Cpu_reset, Wdog_count);
            end else begin
                if (exp_q[0].cyc != cyc || exp_q[0].irq_n !== Irq_n ||
                    exp_q[0].rst !== Cpu_reset || exp_q[0].cnt !== Wdog_count) begin
                    failures <= failures + 1;
                    $display("FAIL event got cyc=%0d irq_n=%b cpu_reset=%b count=%0d required cyc=%0d irq_n=%b cpu_reset=%b count=%0d",
                             cyc, Irq_n, Cpu_reset, Wdog_count,
                             exp_q[0].cyc, exp_q[0].irq_n, exp_q[0].rst, exp_q[0].cnt);
                end
                exp_q.delete(0);
            end
        end
        if (fin_done) begin
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end else if (fin_req) begin
            checks <= checks + 1;
            if (exp_q.size() != 0) begin
                failures <= failures + 1;
                $display("FAIL missing_events got %0d outstanding (next cyc=%0d) required 0",
                         exp_q.size(), exp_q[0].cyc);
            end
            fin_done <= 1'b1;
        end
    end

    initial begin
        repeat (3) @(posedge Clk);
        #1;
        base = cyc;
        expect_ev(0, 1'b1, 1'b0, 0);
        mon_on = 1'b1;

        // Phase 1: IRQ latch with free-running Ce, watchdog off
        expect_ev(4,  1'b0, 1'b0, 0);
        expect_ev(6,  1'b1, 1'b0, 0);
        expect_ev(8,  1'b0, 1'b0, 0);
        expect_ev(10, 1'b1, 1'b0, 0);
        expect_ev(12, 1'b0, 1'b0, 0);
        expect_ev(13, 1'b1, 1'b0, 0);
        expect_ev(16, 1'b0, 1'b0, 0);
        expect_ev(18, 1'b1, 1'b0, 0);
        Reset = 1'b0;
        Ce    = 1'b1;
        goto(6);  Irq_ack = 1'b1;
        goto(7);  Irq_ack = 1'b0;
        goto(10); Irq_ack = 1'b1;
        goto(11); Irq_ack = 1'b0;
        goto(12); Irq_ack = 1'b1;
        goto(15); Irq_ack = 1'b0;
        goto(18); Reset = 1'b1;
        goto(20); Reset = 1'b0; Wdog_en = 1'b1;
        base = cyc;

        // Phase 2: watchdog counting, fire, kicks, reset mid-fire
        expect_ev(4,  1'b0, 1'b0, 1);
        expect_ev(8,  1'b0, 1'b0, 2);
        expect_ev(12, 1'b1, 1'b1, 0);
        expect_ev(17, 1'b1, 1'b0, 0);
        expect_ev(20, 1'b0, 1'b0, 1);
        expect_ev(24, 1'b0, 1'b0, 2);
        expect_ev(28, 1'b0, 1'b0, 0);
        expect_ev(32, 1'b0, 1'b0, 1);
        expect_ev(33, 1'b0, 1'b0, 0);
        expect_ev(36, 1'b0, 1'b0, 1);
        expect_ev(40, 1'b0, 1'b0, 2);
        expect_ev(44, 1'b1, 1'b1, 0);
        expect_ev(46, 1'b1, 1'b0, 0);
        goto(14); Wdog_en = 1'b0; Wdog_kick = 1'b1; Irq_ack = 1'b1;
        goto(15); Wdog_en = 1'b1; Wdog_kick = 1'b0; Irq_ack = 1'b0;
        goto(28); Wdog_kick = 1'b1;
        goto(29); Wdog_kick = 1'b0;
        goto(33); Wdog_kick = 1'b1;
        goto(34); Wdog_kick = 1'b0;
        goto(46); Reset = 1'b1; Wdog_en = 1'b0;
        goto(48); Reset = 1'b0;
        base = cyc;

        // Phase 3: watchdog disabled for 100 ticks, only the first IRQ edge appears
        expect_ev(4, 1'b0, 1'b0, 0);
        for (int k = 1; k <= 400; k++) begin
            goto(k);
            Wdog_kick = (k % 7 == 0);
        end
        expect_ev(402, 1'b1, 1'b0, 0);
        goto(402); Wdog_kick = 1'b0; Reset = 1'b1;
        goto(404); Reset = 1'b0; Ce = 1'b0;
        base = cyc;

        // Phase 4: Ce every third cycle gives ticks twelve cycles apart
        expect_ev(12, 1'b0, 1'b0, 0);
        expect_ev(14, 1'b1, 1'b0, 0);
        expect_ev(24, 1'b0, 1'b0, 0);
        expect_ev(26, 1'b1, 1'b0, 0);
        expect_ev(36, 1'b0, 1'b0, 0);
        for (int k = 1; k <= 40; k++) begin
            goto(k);
            Ce      = (k % 3 == 0);
            Irq_ack = (k == 14 || k == 26);
        end
        goto(44); Ce = 1'b0; Irq_ack = 1'b0;
        fin_req = 1'b1;
    end

endmodule

// File: doc/irq_watchdog_ctrl.md
IRQ_WATCHDOG_CTRL -- requirements
Module: irq_watchdog_ctrl

Interface
REQ-001 SHALL provide parameter IRQ_PERIOD, default 1024, meaning number of Ce ticks between IRQ requests (legal range 2..65535).
REQ-002 SHALL provide parameter WDOG_LIMIT, default 8, meaning number of IRQ periods without a kick before CPU reset fires (legal range 1..255).
REQ-003 SHALL provide parameter RST_CYCLES, default 16, meaning Clk cycles Cpu_reset is held once fired (legal range 1..255).
REQ-004 SHALL provide port Clk, input, 1, the single system clock; all logic is rising-edge Clk.
REQ-005 SHALL provide port Reset, input, 1, synchronous active-high reset.
REQ-006 SHALL provide port Ce, input, 1, timebase clock-enable tick (one Clk cycle wide).
REQ-007 SHALL provide port Irq_ack, input, 1, CPU IRQ-acknowledge write strobe.
REQ-008 SHALL provide port Wdog_kick, input, 1, CPU watchdog-clear write strobe.
REQ-009 SHALL provide port Wdog_en, input, 1, level; 1 enables the watchdog.
REQ-010 SHALL provide port Irq_n, output, 1, active-low IRQ to CPU.
REQ-011 SHALL provide port Cpu_reset, output, 1, active-high CPU reset.
REQ-012 SHALL provide port Wdog_count, output, 8, current missed-period count.

Function
REQ-013 Timebase: 16-bit divider SHALL increment only on Clk cycles with Ce=1; when Ce=1 and divider = IRQ_PERIOD-1 it SHALL wrap to 0 and generate one-cycle internal tick in that same cycle.
REQ-014 IRQ latch SHALL set on the tick; Irq_n SHALL go low the Clk cycle after the tick (1-cycle latency).
REQ-015 IRQ latch SHALL clear on Irq_ack=1; Irq_n SHALL go high the cycle after the ack.
REQ-016 Tick and Irq_ack in same cycle: set SHALL win (latch stays set, new request not lost).
REQ-017 Irq_ack with latch already clear SHALL have no effect.
REQ-018 Watchdog FSM SHALL have states IDLE, RUN, FIRE.
REQ-019 IDLE: Wdog_count held 0; go to RUN when Wdog_en=1.
REQ-020 RUN: Wdog_en=0 -> IDLE with count 0; Wdog_kick=1 -> count 0; else tick -> count+1; when tick occurs with count = WDOG_LIMIT-1 and no kick, go to FIRE.
REQ-021 Kick and tick in same cycle: kick SHALL win (count 0, no FIRE).
REQ-022 FIRE: Cpu_reset=1 for exactly RST_CYCLES Clk cycles, starting the cycle after entry; then Cpu_reset=0, count 0, go to RUN (or IDLE if Wdog_en=0).
REQ-023 During FIRE: IRQ latch SHALL be forced clear, Irq_ack and Wdog_kick ignored, Wdog_en changes take effect only on FIRE exit; timebase divider SHALL keep running.
REQ-024 Wdog_count SHALL never exceed WDOG_LIMIT-1; arithmetic is unsigned 8-bit, no wrap.

Reset
REQ-025 Reset=1 SHALL, at the next Clk edge, clear divider to 0, IRQ latch clear (Irq_n=1), FSM to IDLE, Wdog_count=0, Cpu_reset=0, FIRE counter 0.
REQ-026 Reset SHALL override all inputs, including Ce, Irq_ack and a FIRE in progress (Cpu_reset drops the cycle after Reset).
REQ-027 First tick after Reset release SHALL occur on the IRQ_PERIOD-th Ce tick.

Verification
REQ-028 IRQ_PERIOD=4, Ce=1 every cycle, no ack -> Irq_n low 5 cycles after Reset release and stays low; ack 2 cycles later -> Irq_n high next cycle, low again on next tick.
REQ-029 IRQ_PERIOD=4, Irq_ack asserted exactly in tick cycle -> Irq_n goes/stays low.
REQ-030 IRQ_PERIOD=4, WDOG_LIMIT=3, RST_CYCLES=5, Wdog_en=1, no kicks -> Wdog_count 0,1,2 then Cpu_reset high exactly 5 cycles on third tick, Irq_n forced high during FIRE, Wdog_count=0 after.
REQ-031 Same params, Wdog_kick coincident with third tick -> no FIRE, Wdog_count=0.
REQ-032 Reset asserted mid-FIRE (cycle 2 of 5) -> Cpu_reset=0, Irq_n=1, Wdog_count=0 next cycle; Wdog_en=0 thereafter -> Cpu_reset never fires over 100 ticks.
REQ-033 Ce toggling every 3rd cycle, IRQ_PERIOD=4 -> ticks exactly 12 Clk cycles apart.
